// File: rtl/lsu_pkg.sv
// Shared FSM state, funct3 encodings, request capture record and lane helpers
// for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MERGE = 2'd1,
      RESP  = 2'd2
   } state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Everything latched in the accept cycle and consumed in MERGE/RESP.
   typedef struct packed {
      logic [2:0]  funct3;
      logic [1:0]  off;
      logic        is_store;
      logic        err;
      logic [29:0] waddr;
      logic [31:0] wdata;
      logic [31:0] word;
   } req_t;

   function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  off);
      logic [31:0] res;
      res = old;
      case (funct3)
         F3_B:    res[{off, 3'b000} +: 8]     = wdata[7:0];
         F3_H:    res[{off[1], 4'b0000} +: 16] = wdata[15:0];
         F3_W:    res = wdata;
         default: res = old;
      endcase
      return res;
   endfunction

   // Halfwords ignore off[0] and words ignore off entirely.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (funct3)
         F3_B:    res = {{24{b[7]}}, b};
         F3_BU:   res = {24'd0, b};
         F3_H:    res = {{16{h[15]}}, h};
         F3_HU:   res = {16'd0, h};
         F3_W:    res = word;
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane datapath: store merge for the MERGE write and load extraction/extension
// for the RESP data, both driven from the captured request.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  off_i,
   output logic [31:0] merged_o,
   output logic [31:0] rdata_o
);

   assign merged_o = lane_merge(word_i, wdata_i, funct3_i, off_i);
   assign rdata_o  = load_extend(word_i, funct3_i, off_i);

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store initiator onto a word-only memory (comb read, sync write).
// Define MISALIGN_TRAP_EN to turn misaligned H/HU/W accesses into errors.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS_LOG2 = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [29:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   state_e      state_q, state_d;
   req_t        cap_q, cap_d;
   logic        f3_bad, out_of_range, misaligned, req_err;
   logic [31:0] merged, load_data;

   always_comb begin
      case (req_funct3)
         F3_B, F3_H, F3_W: f3_bad = 1'b0;
         F3_BU, F3_HU:     f3_bad = req_is_store;
         default:          f3_bad = 1'b1;
      endcase
   end

   assign out_of_range = |(req_addr >> (MEM_WORDS_LOG2 + 2));

`ifdef MISALIGN_TRAP_EN
   assign misaligned = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                       ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign req_err = f3_bad || out_of_range || misaligned;

   lsu_align u_align (
      .word_i   (cap_q.word),
      .wdata_i  (cap_q.wdata),
      .funct3_i (cap_q.funct3),
      .off_i    (cap_q.off),
      .merged_o (merged),
      .rdata_o  (load_data)
   );

   // NOTE: every output and next-state value gets a default before the case,
   // so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cap_d      = cap_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_wd     = '0;

      case (state_q)
         IDLE: begin
            // rst gates the accept path so nothing leaks out while reset is held.
            req_ready = !rst;
            if (!rst) mem_addr = req_addr[31:2];
            if (req_valid && !rst) begin
               cap_d.funct3   = req_funct3;
               cap_d.off      = req_addr[1:0];
               cap_d.is_store = req_is_store;
               cap_d.err      = req_err;
               cap_d.waddr    = req_addr[31:2];
               cap_d.wdata    = req_wdata;
               cap_d.word     = mem_rd;
               if (req_err) begin
                  state_d = RESP;
               end else if (req_is_store && (req_funct3 != F3_W)) begin
                  state_d = MERGE;
               end else begin
                  state_d = RESP;
                  if (req_is_store) begin
                     mem_we = 1'b1;
                     mem_wd = req_wdata;
                  end
               end
            end
         end
         MERGE: begin
            mem_addr = cap_q.waddr;
            mem_we   = 1'b1;
            mem_wd   = merged;
            state_d  = RESP;
         end
         RESP: begin
            mem_addr   = cap_q.waddr;
            resp_valid = 1'b1;
            resp_err   = cap_q.err;
            resp_rdata = (cap_q.err || cap_q.is_store) ? 32'd0 : load_data;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
      end
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the execute/memory pipeline stage and the word-organised data memory.
- The data memory has a combinational read, a synchronous write, a word address only, and no byte enables.
- This block turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
  - Sub-word stores use read-modify-write.
  - Loads are lane-extracted and sign- or zero-extended.
- It drives a valid/ready handshake to the pipeline and returns one response per request.

Parameters:
- MEM_WORDS_LOG2, 8: log2 of memory depth in words. Addresses with addr[31:MEM_WORDS_LOG2+2] nonzero are out of range.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  block accepts a request this cycle.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle pulse, response available.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range, or illegal funct3.
- mem_addr  out  30  word address [31:2] to data memory.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data, combinational from mem_addr.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; resp_valid=0; resp_rdata=0; resp_err=0; mem_we=0; mem_wd=0; mem_addr=0; all capture registers=0; req_ready=0 while rst is high.
- FSM states: IDLE, MERGE, RESP.
- req_ready=1 only in IDLE. A request is accepted when req_valid && req_ready.
- Accept cycle (IDLE):
  - mem_addr = req_addr[31:2].
  - The block registers funct3, addr[1:0], is_store, and wdata.
  - Error check: funct3 illegal (011, 11x, or 1xx on a store), or out of range, or misaligned when MISALIGN_TRAP_EN is defined.
    - Error → no memory write; go to RESP with err=1.
  - LW / LB / LH / LBU / LHU: capture mem_rd → RESP. Latency 1: resp_valid in the cycle after accept.
  - SW: mem_we=1 and mem_wd=req_wdata in the accept cycle (combinational from the request) → RESP.
  - SB / SH: capture the old word from mem_rd → MERGE.
- MERGE:
  - mem_addr held at the captured word address.
  - mem_we=1.
  - mem_wd = old word with byte lane addr[1:0] (or halfword lane addr[1]) replaced by wdata[7:0] or [15:0].
  - Next state RESP. Sub-word store latency is 2.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - Loads: byte lane = addr[1:0], half lane = addr[1]. Extend per funct3 (B/H sign-extend, BU/HU zero-extend).
  - Next state IDLE, where req_ready=1 again.
  - Throughput: 2 cycles/op, except 3 for SB/SH.
- mem_we is 0 in every state or cycle not listed above; a single write per store.
- No back-to-back acceptance in RESP. req_valid in RESP is ignored and is not lost: the pipeline holds it until ready.
- Reset mid-MERGE aborts the RMW. The memory word is unchanged because mem_we drops asynchronously. No response is issued.
- Address wrap: none. Out-of-range addresses are never forwarded with mem_we=1.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, produce resp_err=1, resp_rdata=0, and no memory write.
- Undefined:
  - Low address bits are ignored for alignment: halfword uses addr[1], word uses lane 0.
  - The access proceeds normally; resp_err covers only range and funct3.

Decomposition:
- Package lsu_pkg contains:
  - typedef enum for FSM state;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - function lane_merge(old, wdata, funct3, off);
  - function load_extend(word, funct3, off).
- Sub-module lsu_align: combinational lane extraction/extension and store merge, shared by RESP and MERGE.

Test Plan:
- Memory word 0x40 = 0x8899AABB; LB addr 0x41 → resp_rdata 0xFFFFFFAA one cycle after accept; LBU 0x41 → 0x000000AA.
- SH addr 0x42 wdata 0x1234 on word 0x8899AABB → mem_we exactly one cycle (MERGE), mem_wd 0x1234AABB; LW 0x40 → 0x1234AABB.
- SW addr 0x10 wdata 0xDEADBEEF → mem_we in the accept cycle, mem_addr 0x4, resp_valid next cycle, resp_err=0.
- With MISALIGN_TRAP_EN: LW addr 0x102 → resp_err=1, rdata 0, no write. Without it: returns the word at 0x100.
- Out of range: SW addr 0x400 (MEM_WORDS_LOG2=8) → resp_err=1, mem_we never asserted. Illegal funct3 011 → resp_err=1.
- Assert rst during MERGE of SB to 0x20 → mem_we low immediately, word 0x20 unchanged, no resp_valid, req_ready=1 after release.
